periph_slave_buffer: RTL and testbench
======================================

// Module: periph_slave_buffer
// PURPOSE
//  Slave-side adapter between one XBAR_PE peripheral output port (speriph_master[i]) and a
//  variable-latency peripheral. Buffers granted requests in a DEPTH-entry FIFO, issues them one
//  at a time over a ready/valid handshake, returns r_valid/r_id/r_rdata/r_opc to the crossbar,
//  and aborts hung accesses with an error response after TIMEOUT_CYCLES.
// PARAMETERS
//  ADDR_WIDTH     32    address width
//  DATA_WIDTH     32    data width
//  BE_WIDTH       4     byte enables (DATA_WIDTH/8)
//  ID_WIDTH       9     crossbar ID width (NB_CORES+NB_MPERIPHS)
//  DEPTH          2     request FIFO entries (>=1)
//  TIMEOUT_CYCLES 255   cycles in ISSUE+WAIT before abort (>=2)
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           reset, synchronous, active-high
//  req_i        in   1           crossbar request
//  add_i        in   ADDR_WIDTH  address
//  wen_i        in   1           1=read, 0=write
//  wdata_i      in   DATA_WIDTH  write data
//  be_i         in   BE_WIDTH    byte enables
//  id_i         in   ID_WIDTH    requester ID
//  gnt_o        out  1           grant (combinational)
//  r_valid_o    out  1           response valid (registered, 1-cycle pulse)
//  r_opc_o      out  1           response error flag
//  r_id_o       out  ID_WIDTH    response ID
//  r_rdata_o    out  DATA_WIDTH  read data
//  per_req_o    out  1           peripheral request valid
//  per_add_o    out  ADDR_WIDTH  peripheral address
//  per_we_o     out  1           peripheral write (= ~wen)
//  per_wdata_o  out  DATA_WIDTH  peripheral write data
//  per_be_o     out  BE_WIDTH    peripheral byte enables
//  per_ready_i  in   1           peripheral accepts request
//  per_rvalid_i in   1           peripheral response valid (reads and writes)
//  per_rdata_i  in   DATA_WIDTH  peripheral read data
//  per_err_i    in   1           peripheral error, sampled with per_rvalid_i
// BEHAVIOUR
//  Reset: one clock clk_i; reset rst_i synchronous active-high. FIFO empty, FSM=IDLE, timer=0,
//   r_valid_o/r_opc_o/r_id_o/r_rdata_o/per_req_o=0; gnt_o forced 0 while rst_i=1.
//  Accept: gnt_o = req_i & (count<DEPTH) & ~rst_i; push {add,wen,wdata,be,id} on req_i&gnt_o.
//   No full-bypass: a pop in the same cycle does not free a slot for that cycle's request.
//  per_* payload driven from FIFO head. FSM:
//   IDLE : FIFO non-empty -> ISSUE (next cycle). Push into empty FIFO is visible next cycle.
//   ISSUE: per_req_o=1, payload held stable until per_ready_i. per_ready_i&per_rvalid_i -> RESP;
//          per_ready_i only -> WAIT.
//   WAIT : per_req_o=0; per_rvalid_i -> RESP.
//   RESP : r_valid_o=1 one cycle, r_id_o=head id, pop head; -> ISSUE if FIFO still holds
//          another entry, else IDLE.
//  Response data: read -> r_rdata_o=per_rdata_i, r_opc_o=per_err_i captured on per_rvalid_i;
//   write -> r_rdata_o=0, r_opc_o=per_err_i. Outputs zero when r_valid_o=0.
//  Min latency: grant cycle N, per_req_o cycle N+1, rvalid same cycle -> r_valid_o N+2.
//  One outstanding peripheral access; strictly in-order responses.
//  Timer: counts cycles in ISSUE/WAIT, clears on entry to RESP. On reaching TIMEOUT_CYCLES:
//   go RESP with r_opc_o=1, r_rdata_o=32'hBADC0FFE (low DATA_WIDTH bits), per_req_o drops.
//   per_rvalid_i arriving in the timeout cycle: peripheral response wins (no error).
//  per_rvalid_i in IDLE/ISSUE-without-ready/RESP: ignored (stale/late responses discarded).
//  Reset mid-operation: FIFO flushed, in-flight access abandoned, no r_valid_o emitted.
// TESTING
//  1 Read, zero-wait periph (ready=rvalid=1 on first per_req_o), add=0x1A10_0004, id=0x004,
//    rdata=0x1234_5678 -> r_valid_o 2 cycles after gnt, r_id=0x004, rdata=0x12345678, opc=0.
//  2 DEPTH=2, 3 back-to-back reqs, ready delayed 3 cycles -> gnt_o=1,1,0; 3rd granted after
//    first RESP pop +1 cycle; responses IDs in issue order.
//  3 Write wdata=0xCAFEF00D be=4'b0011 -> per_we_o=1, per_be_o=0011, r_rdata_o=0, opc=per_err_i.
//  4 Peripheral never answers, TIMEOUT_CYCLES=8 -> r_valid_o with opc=1, rdata=0xBADC0FFE;
//    later spurious per_rvalid_i produces no response.
//  5 per_err_i=1 with rvalid on read -> opc=1, rdata passed through.
//  6 rst_i asserted in WAIT with 2 entries queued -> next cycle per_req_o=0, FIFO empty,
//    no r_valid_o; new request after release served normally.

Source files
------------

// File: rtl/periph_slave_buffer_if.sv
// Request/response bundle between a crossbar peripheral port, the slave buffer and its peripheral.
// Holds the crossbar request/grant/response group and the peripheral ready/valid group.
// slave is the buffer's view; master is the view of whatever drives both sides of it.
interface periph_slave_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int ID_WIDTH   = 9
);
  // crossbar side
  logic                  req_i;
  logic [ADDR_WIDTH-1:0] add_i;
  logic                  wen_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [BE_WIDTH-1:0]   be_i;
  logic [ID_WIDTH-1:0]   id_i;
  logic                  gnt_o;
  logic                  r_valid_o;
  logic                  r_opc_o;
  logic [ID_WIDTH-1:0]   r_id_o;
  logic [DATA_WIDTH-1:0] r_rdata_o;
  // peripheral side
  logic                  per_req_o;
  logic [ADDR_WIDTH-1:0] per_add_o;
  logic                  per_we_o;
  logic [DATA_WIDTH-1:0] per_wdata_o;
  logic [BE_WIDTH-1:0]   per_be_o;
  logic                  per_ready_i;
  logic                  per_rvalid_i;
  logic [DATA_WIDTH-1:0] per_rdata_i;
  logic                  per_err_i;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
    input  per_ready_i, per_rvalid_i, per_rdata_i, per_err_i,
    output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o,
    output per_req_o, per_add_o, per_we_o, per_wdata_o, per_be_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, id_i,
    output per_ready_i, per_rvalid_i, per_rdata_i, per_err_i,
    input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o,
    input  per_req_o, per_add_o, per_we_o, per_wdata_o, per_be_o
  );
endinterface

// File: rtl/periph_slave_buffer.sv
// Buffers crossbar requests in a DEPTH-entry FIFO and plays them one at a time to a peripheral.
// Latency: grant in cycle N -> per_req_o in N+1 -> r_valid_o in N+2 for a zero-wait peripheral.
// Backpressure: gnt_o drops while the FIFO is full (no same-cycle bypass); hung accesses time out.
module periph_slave_buffer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int ID_WIDTH       = 9,
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk_i,
  input logic                  rst_i,
  periph_slave_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [31:0]           ERR_WORD = 32'hBADC_0FFE;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_WORD);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  req_t                  mem [DEPTH];
  req_t                  head;
  req_t                  in_req;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  gnt;
  logic                  push;
  logic                  pop;
  logic                  more_work;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] ok_rdata;

  state_t                state;
  logic [TMR_W-1:0]      timer;
  logic                  per_req_q;
  logic                  r_valid_q;
  logic                  r_opc_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A slot freed by this cycle's pop is not offered to this cycle's request.
  assign gnt  = bus.req_i & (count < CNT_W'(DEPTH)) & ~rst_i;
  assign push = bus.req_i & gnt;
  assign pop  = (state == S_RESP);

  assign in_req = '{add: bus.add_i, wen: bus.wen_i, wdata: bus.wdata_i,
                    be: bus.be_i, id: bus.id_i};
  assign head   = mem[rd_ptr];

  // After the current pop, is there something left (or arriving) to issue next?
  assign more_work = (count > CNT_W'(1)) | push;
  assign timed_out = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  // Writes return zero data; reads pass the peripheral data through.
  assign ok_rdata  = head.wen ? bus.per_rdata_i : '0;

  // Payload storage; entries are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Access sequencer: one outstanding access, timer covers ISSUE+WAIT, outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      timer     <= '0;
      per_req_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (push || count != '0) begin
            state     <= S_ISSUE;
            per_req_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.per_ready_i && bus.per_rvalid_i) begin
            state     <= S_RESP;
            per_req_q <= 1'b0;
            timer     <= '0;
            r_valid_q <= 1'b1;
            r_id_q    <= head.id;
            r_opc_q   <= bus.per_err_i;
            r_rdata_q <= ok_rdata;
          end else if (timed_out) begin
            state     <= S_RESP;
            per_req_q <= 1'b0;
            timer     <= '0;
            r_valid_q <= 1'b1;
            r_id_q    <= head.id;
            r_opc_q   <= 1'b1;
            r_rdata_q <= ERR_DATA;
          end else if (bus.per_ready_i) begin
            state     <= S_WAIT;
            per_req_q <= 1'b0;
            timer     <= timer + TMR_W'(1);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WAIT: begin
          // A response landing in the timeout cycle still wins over the abort.
          if (bus.per_rvalid_i) begin
            state     <= S_RESP;
            timer     <= '0;
            r_valid_q <= 1'b1;
            r_id_q    <= head.id;
            r_opc_q   <= bus.per_err_i;
            r_rdata_q <= ok_rdata;
          end else if (timed_out) begin
            state     <= S_RESP;
            timer     <= '0;
            r_valid_q <= 1'b1;
            r_id_q    <= head.id;
            r_opc_q   <= 1'b1;
            r_rdata_q <= ERR_DATA;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_RESP: begin
          timer <= '0;
          if (more_work) begin
            state     <= S_ISSUE;
            per_req_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          per_req_q <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.r_valid_o   = r_valid_q;
  assign bus.r_opc_o     = r_opc_q;
  assign bus.r_id_o      = r_id_q;
  assign bus.r_rdata_o   = r_rdata_q;
  assign bus.per_req_o   = per_req_q;
  assign bus.per_add_o   = head.add;
  assign bus.per_we_o    = ~head.wen;
  assign bus.per_wdata_o = head.wdata;
  assign bus.per_be_o    = head.be;
endmodule

// File: tb/tb_periph_slave_buffer.sv
// Bench for periph_slave_buffer: directed scenarios followed by a randomized run.
// A transaction-level model predicts grants, peripheral requests and responses cycle by cycle.
// The bench plays both the crossbar and the peripheral through the interface.
module tb_periph_slave_buffer;
  localparam int AW = 32, DW = 32, BW = 4, IW = 9, DEPTH = 2, TO = 8;
  localparam logic [31:0] ERR_WORD = 32'hBADC_0FFE;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  periph_slave_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW)) bus ();

  periph_slave_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW),
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [IW-1:0] id;
    int            pc;   // cycle in which it was granted
  } txn_t;

  int total = 0;
  int bad   = 0;

  // reference model state
  txn_t          q[$];
  int            cyc = 0;
  int            last_rv = -10;
  bit            acc = 0, done = 0, exp_rv = 0, exp_opc = 0;
  logic [IW-1:0] exp_id = '0;
  logic [DW-1:0] exp_rdata = '0;
  int            req_seen = 0, acc_seen = 0;

  // peripheral behaviour knobs
  int            rdy_dly = 0, rsp_dly = 0;
  bit            silent = 0, spur = 0, force_rv = 0, rand_mode = 0;
  logic [DW-1:0] p_rdata = '0;
  bit            p_err = 0;

  // crossbar payload
  logic [AW-1:0] d_add = '0;
  logic          d_wen = 1'b1;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [IW-1:0] d_id = '0;

  // observations
  bit            gnt_seen = 0, prev_preq = 0;
  int            obs_rv_cyc = -1, first_rv_cyc = -1, obs_preq_cyc = -1;
  logic [DW-1:0] obs_rdata = '0;
  logic          obs_opc = 1'b0, obs_we = 1'b0;
  logic [IW-1:0] obs_id = '0;
  logic [BW-1:0] obs_be = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input logic [BW-1:0] b, input logic [IW-1:0] i);
    d_add = a; d_wen = w; d_wdata = wd; d_be = b; d_id = i;
  endtask

  task automatic randomize_policy();
    rdy_dly = $urandom_range(0, 3);
    rsp_dly = $urandom_range(0, 4);
    silent  = ($urandom_range(0, 7) == 0);
    p_rdata = $urandom;
    p_err   = ($urandom_range(0, 3) == 0);
  endtask

  // One clock cycle: check outputs, act as peripheral and crossbar, advance the model.
  task automatic tick(input bit rst_v, input bit req_v);
    bit live, exp_pr, to_cyc, rdy, rv, ev, ev_ok, acc_next, gnt_exp;
    int start, elapsed;
    live = 0; start = 0; ev = 0; ev_ok = 0; acc_next = 0;
    @(negedge clk_i);
    check("r_valid", bus.r_valid_o, exp_rv);
    check("r_id", bus.r_id_o, exp_id);
    check("r_rdata", bus.r_rdata_o, exp_rdata);
    check("r_opc", bus.r_opc_o, exp_opc);
    if (bus.r_valid_o === 1'b1) begin
      obs_rv_cyc = cyc; obs_rdata = bus.r_rdata_o; obs_opc = bus.r_opc_o; obs_id = bus.r_id_o;
      if (first_rv_cyc < 0) first_rv_cyc = cyc;
    end
    if (bus.per_req_o === 1'b1) begin
      if (!prev_preq) obs_preq_cyc = cyc;
      obs_we = bus.per_we_o; obs_be = bus.per_be_o;
    end
    prev_preq = (bus.per_req_o === 1'b1);

    if (q.size() > 0 && !done) begin
      start = (q[0].pc + 1 > last_rv + 1) ? q[0].pc + 1 : last_rv + 1;
      live  = (cyc >= start);
    end
    elapsed = cyc - start;
    exp_pr  = live && !acc;
    to_cyc  = live && (elapsed == TO - 1);
    check("per_req", bus.per_req_o, exp_pr);
    if (exp_pr) begin
      check("per_add", bus.per_add_o, q[0].add);
      check("per_we", bus.per_we_o, !q[0].wen);
      check("per_wdata", bus.per_wdata_o, q[0].wdata);
      check("per_be", bus.per_be_o, q[0].be);
    end

    rdy = exp_pr && !silent && (req_seen >= rdy_dly);
    rv  = !silent && ((rdy && rsp_dly == 0) || (acc && acc_seen + 1 >= rsp_dly));
    if (!rv && !acc && !rdy && (force_rv || (spur && $urandom_range(0, 3) == 0))) rv = 1;
    bus.per_ready_i  = rdy;
    bus.per_rvalid_i = rv;
    bus.per_rdata_i  = rv ? p_rdata : DW'($urandom);
    bus.per_err_i    = rv ? p_err : 1'($urandom_range(0, 1));
    rst_i       = rst_v;
    bus.req_i   = req_v;
    bus.add_i   = d_add;
    bus.wen_i   = d_wen;
    bus.wdata_i = d_wdata;
    bus.be_i    = d_be;
    bus.id_i    = d_id;

    if (!rst_v && live) begin
      if (!acc) begin
        if (rdy && rv) begin ev = 1; ev_ok = 1; end
        else if (to_cyc) ev = 1;
        else if (rdy) acc_next = 1;
      end else begin
        if (rv) begin ev = 1; ev_ok = 1; end
        else if (to_cyc) ev = 1;
      end
    end

    #1;
    gnt_exp = req_v && !rst_v && (q.size() < DEPTH);
    check("gnt", bus.gnt_o, gnt_exp);
    gnt_seen = (bus.gnt_o === 1'b1);

    if (rst_v) begin
      q.delete();
      acc = 0; done = 0; exp_rv = 0; exp_opc = 0; exp_id = '0; exp_rdata = '0;
      last_rv = -10; req_seen = 0; acc_seen = 0;
    end else begin
      if (ev) begin
        done      = 1;
        exp_id    = q[0].id;
        exp_rdata = ev_ok ? (q[0].wen ? p_rdata : '0) : DW'(ERR_WORD);
        exp_opc   = ev_ok ? p_err : 1'b1;
      end else begin
        exp_id = '0; exp_rdata = '0; exp_opc = 0;
      end
      if (exp_rv) begin
        void'(q.pop_front());
        last_rv = cyc; done = 0; acc = 0; req_seen = 0; acc_seen = 0;
        if (rand_mode) randomize_policy();
      end else begin
        if (exp_pr) req_seen++;
        if (acc) acc_seen++;
        if (acc_next) acc = 1;
      end
      exp_rv = ev;
      if (gnt_exp) q.push_back('{d_add, d_wen, d_wdata, d_be, d_id, cyc});
    end
    cyc++;
  endtask

  task automatic wait_gnt(input string tag, output int gcyc);
    int n;
    n = 0;
    do begin
      gcyc = cyc;
      tick(1'b0, 1'b1);
      n++;
    end while (!gnt_seen && n < 50);
    check(tag, gnt_seen, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() > 0 || exp_rv) && n < 300) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check(tag, (n < 300), 1'b1);
  endtask

  initial begin
    int g, g1, g2, g3, s1;
    bus.req_i = 0; bus.add_i = '0; bus.wen_i = 1; bus.wdata_i = '0; bus.be_i = '0; bus.id_i = '0;
    bus.per_ready_i = 0; bus.per_rvalid_i = 0; bus.per_rdata_i = '0; bus.per_err_i = 0;
    repeat (2) @(posedge clk_i);

    // reset state: outputs idle, grant forced low while reset is held
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);

    // 1: zero-wait read
    set_req(32'h1A10_0004, 1'b1, '0, 4'hF, 9'h004);
    p_rdata = 32'h1234_5678; p_err = 0;
    wait_gnt("t1_gnt", g);
    drain("t1_drain");
    check("t1_latency", obs_rv_cyc - g, 2);
    check("t1_id", obs_id, 9'h004);
    check("t1_rdata", obs_rdata, 32'h1234_5678);
    check("t1_opc", obs_opc, 1'b0);

    // 2: three back-to-back requests, ready delayed 3 cycles
    rdy_dly = 3; first_rv_cyc = -1;
    set_req(32'h1A10_0010, 1'b1, '0, 4'hF, 9'h010);
    tick(1'b0, 1'b1);
    check("t2_gnt_a", gnt_seen, 1'b1);
    set_req(32'h1A10_0014, 1'b1, '0, 4'hF, 9'h011);
    tick(1'b0, 1'b1);
    check("t2_gnt_b", gnt_seen, 1'b1);
    set_req(32'h1A10_0018, 1'b1, '0, 4'hF, 9'h012);
    tick(1'b0, 1'b1);
    check("t2_gnt_c_first", gnt_seen, 1'b0);
    wait_gnt("t2_gnt_c", g3);
    check("t2_gnt_c_after_pop", g3, first_rv_cyc + 1);
    drain("t2_drain");
    check("t2_last_id", obs_id, 9'h012);

    // 3: write with partial byte enables and an error flag
    rdy_dly = 0; rsp_dly = 1; p_rdata = 32'h5555_AAAA; p_err = 1;
    set_req(32'h1A10_0020, 1'b0, 32'hCAFE_F00D, 4'b0011, 9'h0A3);
    wait_gnt("t3_gnt", g);
    drain("t3_drain");
    check("t3_we", obs_we, 1'b1);
    check("t3_be", obs_be, 4'b0011);
    check("t3_rdata", obs_rdata, '0);
    check("t3_opc", obs_opc, 1'b1);

    // 4: peripheral never answers -> timeout, then stale responses are dropped
    silent = 1; rdy_dly = 1000;
    set_req(32'h1A10_0030, 1'b1, '0, 4'hF, 9'h1FF);
    wait_gnt("t4_gnt", g);
    drain("t4_drain");
    check("t4_latency", obs_rv_cyc - obs_preq_cyc, TO);
    check("t4_id", obs_id, 9'h1FF);
    check("t4_opc", obs_opc, 1'b1);
    check("t4_rdata", obs_rdata, ERR_WORD);
    silent = 0; rdy_dly = 0; force_rv = 1;
    g1 = obs_rv_cyc;
    repeat (6) tick(1'b0, 1'b0);
    force_rv = 0;
    check("t4_no_spurious_resp", obs_rv_cyc, g1);

    // 5: read with peripheral error, data passed through
    rdy_dly = 1; rsp_dly = 2; p_rdata = 32'hA5A5_5A5A; p_err = 1;
    set_req(32'h1A10_0040, 1'b1, '0, 4'hF, 9'h055);
    wait_gnt("t5_gnt", g);
    drain("t5_drain");
    check("t5_opc", obs_opc, 1'b1);
    check("t5_rdata", obs_rdata, 32'hA5A5_5A5A);

    // 6: reset while waiting with the FIFO full
    rdy_dly = 0; rsp_dly = 100; p_err = 0;
    set_req(32'h1A10_0050, 1'b1, '0, 4'hF, 9'h061);
    wait_gnt("t6_gnt_a", g);
    set_req(32'h1A10_0054, 1'b1, '0, 4'hF, 9'h062);
    wait_gnt("t6_gnt_b", g);
    tick(1'b0, 1'b0);
    g1 = obs_rv_cyc;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("t6_no_resp", obs_rv_cyc, g1);
    rsp_dly = 0; p_rdata = 32'h0BAD_BEEF;
    set_req(32'h1A10_0060, 1'b1, '0, 4'hF, 9'h071);
    s1 = cyc;
    wait_gnt("t6_gnt_c", g1);
    set_req(32'h1A10_0064, 1'b1, '0, 4'hF, 9'h072);
    wait_gnt("t6_gnt_d", g2);
    check("t6_empty_after_reset", g2 - s1, 1);
    drain("t6_drain");
    check("t6_last_id", obs_id, 9'h072);

    // randomized traffic, peripheral timing, stale responses and occasional resets
    rand_mode = 1; spur = 1;
    randomize_policy();
    for (int i = 0; i < 800; i++) begin
      set_req(AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom), BW'($urandom), IW'($urandom));
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1));
    end
    spur = 0; rand_mode = 0; silent = 0;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
